// File: rtl/spu_writeback.sv
// Writer side of the SPU register file: queues even/odd pipe results, drains them
// one per cycle onto the single write port, and forwards pending data to operand reads.
module spu_writeback #(
  parameter int RFWIDTH = 128,
  parameter int REGBITS = 7,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               even_valid,
  input  logic [REGBITS-1:0] even_rt,
  input  logic [RFWIDTH-1:0] even_wd,
  input  logic               odd_valid,
  input  logic [REGBITS-1:0] odd_rt,
  input  logic [RFWIDTH-1:0] odd_wd,
  output logic               stall,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [RFWIDTH-1:0] wd,
  input  logic [REGBITS-1:0] fwd_a_addr,
  input  logic [REGBITS-1:0] fwd_b_addr,
  output logic               fwd_a_hit,
  output logic               fwd_b_hit,
  output logic [RFWIDTH-1:0] fwd_a_data,
  output logic [RFWIDTH-1:0] fwd_b_data,
  output logic [2:0]         count,
  output logic               overflow
);

  localparam int         PTRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  logic [REGBITS-1:0] q_rt   [DEPTH];
  logic [RFWIDTH-1:0] q_data [DEPTH];
  logic [PTRW-1:0]    head;
  logic [PTRW-1:0]    tail;
  logic [PTRW-1:0]    odd_slot;
  logic [PTRW-1:0]    fwd_ptr;
  logic [3:0]         space;
  logic               pop;
  logic               even_acc;
  logic               odd_acc;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // The slot freed by this cycle's pop is usable by the incoming pushes.
  always_comb begin
    pop      = (count != 3'd0);
    space    = DEPTH_W - {1'b0, count} + {3'b000, pop};
    even_acc = even_valid && (space >= 4'd1);
    odd_acc  = odd_valid && (space >= (even_acc ? 4'd2 : 4'd1));
    odd_slot = even_acc ? ptr_inc(tail) : tail;
  end

  assign stall = ({1'b0, count} > (DEPTH_W - 4'd2));

  // Walk candidates oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_a_hit  = regwrite && (wa == fwd_a_addr);
    fwd_b_hit  = regwrite && (wa == fwd_b_addr);
    fwd_a_data = fwd_a_hit ? wd : '0;
    fwd_b_data = fwd_b_hit ? wd : '0;
    fwd_ptr    = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i) < count) begin
        if (q_rt[fwd_ptr] == fwd_a_addr) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = q_data[fwd_ptr];
        end
        if (q_rt[fwd_ptr] == fwd_b_addr) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = q_data[fwd_ptr];
        end
      end
      fwd_ptr = ptr_inc(fwd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      regwrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rt[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      regwrite <= pop;
      if (pop) begin
        wa   <= q_rt[head];
        wd   <= q_data[head];
        head <= ptr_inc(head);
      end
      if (even_acc) begin
        q_rt[tail]   <= even_rt;
        q_data[tail] <= even_wd;
      end
      if (odd_acc) begin
        q_rt[odd_slot]   <= odd_rt;
        q_data[odd_slot] <= odd_wd;
        tail             <= ptr_inc(odd_slot);
      end else if (even_acc) begin
        tail <= ptr_inc(tail);
      end
      count <= count + {2'b00, even_acc} + {2'b00, odd_acc} - {2'b00, pop};
      if ((even_valid && !even_acc) || (odd_valid && !odd_acc))
        overflow <= 1'b1;
    end
  end

endmodule
